// File: rtl/coin_credit_if.sv
// coin_credit_if: groups the coin/debit/return/hopper signals of the coin_credit
// payment front end so they can be passed as one port.
//   master modport : stimulus side (drives Coin, Debit*, Return_req, Hopper_ready)
//   slave  modport : coin_credit side (drives Money, status pulses, Change_out, Busy)
interface coin_credit_if;
  logic [2:0] Coin;
  logic       Debit_valid;
  logic [6:0] Debit;
  logic       Return_req;
  logic       Hopper_ready;
  logic [6:0] Money;
  logic       Debit_ack;
  logic       Debit_err;
  logic       Coin_reject;
  logic [2:0] Change_out;
  logic       Busy;

  modport master (
    output Coin, Debit_valid, Debit, Return_req, Hopper_ready,
    input  Money, Debit_ack, Debit_err, Coin_reject, Change_out, Busy
  );

  modport slave (
    input  Coin, Debit_valid, Debit, Return_req, Hopper_ready,
    output Money, Debit_ack, Debit_err, Coin_reject, Change_out, Busy
  );
endinterface

// File: rtl/coin_credit.sv
// coin_credit: payment front end. Accumulates one-hot coin pulses into a 7-bit
// credit (Money), applies vend debits, and on a return request pays the credit
// back one coin at a time (largest first) through the hopper handshake.
//
// Ports:
//   Clk      : single clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : coin_credit_if.slave (Coin, Debit_valid, Debit, Return_req,
//              Hopper_ready in; Money, Debit_ack, Debit_err, Coin_reject,
//              Change_out, Busy out -- all outputs registered)
//
// Optional feature: define COIN_CREDIT_TIMEOUT_EN to add an idle timer that
// starts change return after TIMEOUT quiet cycles with nonzero credit.
//
// state  | meaning
// IDLE   | accepting coins and debits
// CHANGE | paying out credit; coins rejected, debits refused
module coin_credit #(
  parameter int MAX_CREDIT = 125,
  parameter int TIMEOUT    = 1000
) (
  input logic       Clk,
  input logic       Reset_n,
  coin_credit_if.slave bus
);

  if ((MAX_CREDIT % 5) != 0 || MAX_CREDIT > 127 || MAX_CREDIT < 5) begin : g_bad_max
    $error("coin_credit: MAX_CREDIT must be a multiple of 5 in 5..127");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("coin_credit: TIMEOUT must be in 2..65535");
  end

  typedef enum logic {IDLE, CHANGE} state_t;

  localparam logic [7:0] MAX8 = 8'(MAX_CREDIT);

  state_t     state;
  logic [6:0] money;
  logic       debit_ack, debit_err, coin_reject, busy;
  logic [2:0] change_out;

  logic [7:0] coin_val;
  logic       coin_onehot;
  logic       coin_ok, coin_bad, debit_ok;
  logic [7:0] money_sum;
  logic [2:0] chg_code;
  logic [6:0] chg_val;
  logic       timeout_fire;

  always_comb begin
    coin_val    = 8'd0;
    coin_onehot = 1'b1;
    case (bus.Coin)
      3'b001:  coin_val = 8'd5;
      3'b010:  coin_val = 8'd10;
      3'b100:  coin_val = 8'd25;
      default: coin_onehot = 1'b0;
    endcase
  end

  // Overflow check is against the pre-debit credit, so a same-cycle debit
  // cannot make room for a coin.
  assign coin_ok   = coin_onehot && (({1'b0, money} + coin_val) <= MAX8);
  assign coin_bad  = (|bus.Coin) && !coin_ok;
  assign debit_ok  = bus.Debit_valid && (bus.Debit <= money) &&
                     ((bus.Debit % 7'd5) == 7'd0);
  assign money_sum = {1'b0, money} + (coin_ok ? coin_val : 8'd0)
                   - (debit_ok ? {1'b0, bus.Debit} : 8'd0);

  always_comb begin
    chg_code = 3'b001;
    chg_val  = 7'd5;
    if (money >= 7'd25) begin
      chg_code = 3'b100;
      chg_val  = 7'd25;
    end else if (money >= 7'd10) begin
      chg_code = 3'b010;
      chg_val  = 7'd10;
    end
  end

`ifdef COIN_CREDIT_TIMEOUT_EN
  logic [15:0] idle_timer;
  logic        activity;

  assign activity     = (|bus.Coin) || bus.Debit_valid || bus.Return_req;
  assign timeout_fire = (state == IDLE) && !activity && (money != 7'd0) &&
                        (idle_timer == 16'(TIMEOUT - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idle_timer <= 16'd0;
    end else if (state != IDLE || activity || money == 7'd0 || timeout_fire) begin
      idle_timer <= 16'd0;
    end else begin
      idle_timer <= idle_timer + 16'd1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      money       <= 7'd0;
      debit_ack   <= 1'b0;
      debit_err   <= 1'b0;
      coin_reject <= 1'b0;
      change_out  <= 3'b000;
      busy        <= 1'b0;
    end else begin
      debit_ack   <= 1'b0;
      debit_err   <= 1'b0;
      coin_reject <= 1'b0;
      change_out  <= 3'b000;
      case (state)
        IDLE: begin
          money       <= money_sum[6:0];
          debit_ack   <= debit_ok;
          debit_err   <= bus.Debit_valid && !debit_ok;
          coin_reject <= coin_bad;
          if ((bus.Return_req || timeout_fire) && money_sum != 8'd0) begin
            state <= CHANGE;
            busy  <= 1'b1;
          end
        end
        CHANGE: begin
          coin_reject <= |bus.Coin;
          debit_err   <= bus.Debit_valid;
          if (bus.Hopper_ready) begin
            change_out <= chg_code;
            money      <= money - chg_val;
            // Credit is always a multiple of 5, so the last coin lands on 0.
            if (money == chg_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Money       = money;
  assign bus.Debit_ack   = debit_ack;
  assign bus.Debit_err   = debit_err;
  assign bus.Coin_reject = coin_reject;
  assign bus.Change_out  = change_out;
  assign bus.Busy        = busy;

endmodule

// File: tb/tb_coin_credit.sv
// Testbench for coin_credit: directed vectors push their hand-computed
// expected output into a scoreboard queue; a monitor pops and compares.
module tb_coin_credit;
  logic Clk;
  logic Reset_n;
  coin_credit_if bus ();

  coin_credit #(.MAX_CREDIT(125), .TIMEOUT(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    logic [13:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  function automatic logic [13:0] outv();
    return {bus.Money, bus.Debit_ack, bus.Debit_err, bus.Coin_reject,
            bus.Change_out, bus.Busy};
  endfunction

  task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got money=%0d ack=%b err=%b rej=%b chg=%b busy=%b, want money=%0d ack=%b err=%b rej=%b chg=%b busy=%b",
                  nm, got[13:7], got[6], got[5], got[4], got[3:1], got[0],
                  exp[13:7], exp[6], exp[5], exp[4], exp[3:1], exp[0]);
  endtask

  // Monitor: compare the expectation due on the edge just past.
  initial begin
    exp_t t;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        t = sb.pop_front();
        check(t.name, outv(), t.exp);
      end
    end
  end

  task automatic drive(input logic [2:0] c, input logic dv, input logic [6:0] d,
                       input logic rr, input logic hr);
    bus.Coin         = c;
    bus.Debit_valid  = dv;
    bus.Debit        = d;
    bus.Return_req   = rr;
    bus.Hopper_ready = hr;
  endtask

  task automatic step(input logic [2:0] c, input logic dv, input logic [6:0] d,
                      input logic rr, input logic hr,
                      input logic [6:0] m, input logic a, input logic e,
                      input logic rj, input logic [2:0] ch, input logic b,
                      input string nm);
    exp_t t;
    @(posedge Clk);
    #1;
    drive(c, dv, d, rr, hr);
    t.due  = cyc + 1;
    t.exp  = {m, a, e, rj, ch, b};
    t.name = nm;
    sb.push_back(t);
  endtask

  task automatic drain();
    @(posedge Clk);
    #1;
    drive(3'b000, 1'b0, 7'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    drive(3'b000, 1'b0, 7'd0, 1'b0, 1'b0);
    #1;
    check("reset_state", outv(), 14'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    //    coin    dv  deb  rr hr   money a e rj chg    busy
    step(3'b100, 0, 0,  0, 0,  25, 0,0,0, 3'b000, 0, "coin25a");
    step(3'b100, 0, 0,  0, 0,  50, 0,0,0, 3'b000, 0, "coin25b");
    step(3'b010, 0, 0,  0, 0,  60, 0,0,0, 3'b000, 0, "coin10");
    step(3'b000, 1, 30, 0, 0,  30, 1,0,0, 3'b000, 0, "debit30");
    step(3'b000, 1, 35, 0, 0,  30, 0,1,0, 3'b000, 0, "debit35_over");
    step(3'b000, 1, 12, 0, 0,  30, 0,1,0, 3'b000, 0, "debit12_notmul5");
    step(3'b100, 0, 0,  0, 0,  55, 0,0,0, 3'b000, 0, "fill55");
    step(3'b100, 0, 0,  0, 0,  80, 0,0,0, 3'b000, 0, "fill80");
    step(3'b100, 0, 0,  0, 0, 105, 0,0,0, 3'b000, 0, "fill105");
    step(3'b010, 0, 0,  0, 0, 115, 0,0,0, 3'b000, 0, "fill115");
    step(3'b001, 0, 0,  0, 0, 120, 0,0,0, 3'b000, 0, "fill120");
    step(3'b010, 0, 0,  0, 0, 120, 0,0,1, 3'b000, 0, "coin10_overflow");
    step(3'b011, 0, 0,  0, 0, 120, 0,0,1, 3'b000, 0, "coin_multi");
    step(3'b001, 0, 0,  0, 0, 125, 0,0,0, 3'b000, 0, "coin5_to_max");
    step(3'b001, 0, 0,  0, 0, 125, 0,0,1, 3'b000, 0, "coin5_over_max");
    step(3'b000, 1, 60, 0, 0,  65, 1,0,0, 3'b000, 0, "debit60");
    step(3'b000, 0, 0,  1, 0,  65, 0,0,0, 3'b000, 1, "return_enter");
    step(3'b000, 0, 0,  0, 1,  40, 0,0,0, 3'b100, 1, "chg25a");
    step(3'b010, 0, 0,  1, 0,  40, 0,0,1, 3'b000, 1, "chg_hold_coinrej");
    step(3'b000, 1, 5,  0, 1,  15, 0,1,0, 3'b100, 1, "chg25b_debiterr");
    step(3'b000, 0, 0,  0, 1,   5, 0,0,0, 3'b010, 1, "chg10");
    step(3'b000, 0, 0,  0, 1,   0, 0,0,0, 3'b001, 0, "chg5_last");
    step(3'b000, 0, 0,  1, 0,   0, 0,0,0, 3'b000, 0, "return_zero");
    step(3'b001, 0, 0,  0, 0,   5, 0,0,0, 3'b000, 0, "coin5");
    step(3'b010, 0, 0,  0, 0,  15, 0,0,0, 3'b000, 0, "coin10_to15");
    step(3'b010, 1, 20, 0, 0,  25, 0,1,0, 3'b000, 0, "coin_debit_err");
    step(3'b001, 0, 0,  1, 0,  30, 0,0,0, 3'b000, 1, "coin_return");
    step(3'b000, 0, 0,  0, 1,   5, 0,0,0, 3'b100, 1, "chg25c");
    step(3'b000, 0, 0,  0, 1,   0, 0,0,0, 3'b001, 0, "chg5b_last");
    step(3'b100, 0, 0,  0, 0,  25, 0,0,0, 3'b000, 0, "coin25c");
    step(3'b010, 1, 20, 0, 0,  15, 1,0,0, 3'b000, 0, "coin_debit_ok");
    step(3'b100, 0, 0,  0, 0,  40, 0,0,0, 3'b000, 0, "refill40");
    step(3'b100, 0, 0,  0, 0,  65, 0,0,0, 3'b000, 0, "refill65");
    step(3'b100, 0, 0,  0, 0,  90, 0,0,0, 3'b000, 0, "refill90");
    step(3'b100, 0, 0,  0, 0, 115, 0,0,0, 3'b000, 0, "refill115");
    step(3'b001, 0, 0,  0, 0, 120, 0,0,0, 3'b000, 0, "refill120");
    step(3'b010, 1, 50, 0, 0,  70, 1,0,1, 3'b000, 0, "coin_ovf_debit_ok");
    step(3'b000, 0, 0,  1, 0,  70, 0,0,0, 3'b000, 1, "return70");
    step(3'b000, 0, 0,  0, 1,  45, 0,0,0, 3'b100, 1, "chg25_pre_reset");
    drain();

    // Asynchronous reset in the middle of paying out change.
    bus.Hopper_ready = 1'b1;
    Reset_n = 1'b0;
    #1;
    check("reset_mid_change", outv(), 14'd0);
    @(posedge Clk);
    #1;
    check("reset_held", outv(), 14'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(3'b000, 0, 0,  0, 1,   0, 0,0,0, 3'b000, 0, "post_reset_idle");

`ifdef COIN_CREDIT_TIMEOUT_EN
    step(3'b010, 0, 0,  0, 0,  10, 0,0,0, 3'b000, 0, "to_coin10");
    step(3'b001, 0, 0,  0, 0,  15, 0,0,0, 3'b000, 0, "to_coin5");
    for (int i = 0; i < 7; i++)
      step(3'b000, 0, 0, 0, 0, 15, 0,0,0, 3'b000, 0, "to_wait");
    step(3'b000, 0, 0,  0, 0,  15, 0,0,0, 3'b000, 1, "timeout_enter");
    step(3'b000, 0, 0,  0, 1,   5, 0,0,0, 3'b010, 1, "to_chg10");
    step(3'b000, 0, 0,  0, 1,   0, 0,0,0, 3'b001, 0, "to_chg5_last");
`endif
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
